// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one clocked ALU between NUM_REQ requesters. One request
//               is granted per cycle. The granted operands are registered onto
//               the ALU ports. A tag pipeline matched to ALU_LATENCY routes each
//               result back to its owner as a one-cycle pulse.
// Build macro : ALU_ARB_FIXED_PRIO_EN - when defined, fixed priority is used and
//               the lowest index wins. When undefined, round-robin is used.
// Ports       : clock, reset        - rising-edge clock, sync active-high reset
//               req_valid/req_ready - per-requester handshake (ready one-hot)
//               req_a/req_b/req_op  - packed per-requester operands/opcode
//               alu_a_out/b_out/op_out - registered operands to the ALU
//               alu_result_in       - ALU result
//               resp_valid/resp_result - one-hot result pulse + data
//               busy                - any operation in flight or responding
//               issue_count         - accepted operations, wrapping 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int OP_W        = 4,
    parameter int RES_W       = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         alu_a_out,
    output logic [DATA_W-1:0]         alu_b_out,
    output logic [OP_W-1:0]           alu_op_out,
    input  logic [RES_W-1:0]          alu_result_in,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [RES_W-1:0]          resp_result,
    output logic                      busy,
    output logic [15:0]               issue_count
);

    localparam int C_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int C_STAGES = ALU_LATENCY + 1;
    localparam int C_LAST   = ALU_LATENCY;
    localparam logic [NUM_REQ-1:0] C_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic                 w_grant_found;
    logic [C_IDX_W-1:0]   w_grant_idx;
    logic [C_IDX_W-1:0]   w_search_base;
    logic [C_IDX_W-1:0]   w_cand_idx;
    int                   w_cand;
    logic                 w_handshake;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;
    logic [OP_W-1:0]      w_sel_op;

    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0]      alu_op_q, alu_op_d;
    logic [C_STAGES-1:0]  tag_vld_q, tag_vld_d;
    logic [C_IDX_W-1:0]   tag_idx_q [C_STAGES];
    logic [C_IDX_W-1:0]   tag_idx_d [C_STAGES];
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [RES_W-1:0]     resp_result_q, resp_result_d;
    logic [15:0]          issue_count_q, issue_count_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_search_base = '0;
`else
    logic [C_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    assign w_search_base = rr_ptr_q;
`endif

    // Search ascending from the base index, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = 0;
        w_cand_idx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = int'(w_search_base) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = C_IDX_W'(w_cand);
            if (!w_grant_found && req_valid[w_cand_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand_idx;
            end
        end
    end

    // No grant is offered while reset is held.
    assign w_handshake = w_grant_found & ~reset;
    assign req_ready   = w_handshake ? (C_ONE << w_grant_idx) : '0;

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(w_grant_idx)) begin
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
                w_sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        alu_a_d       = w_handshake ? w_sel_a  : alu_a_q;
        alu_b_d       = w_handshake ? w_sel_b  : alu_b_q;
        alu_op_d      = w_handshake ? w_sel_op : alu_op_q;
        issue_count_d = issue_count_q + {15'd0, w_handshake};

        // The last tag stage lines up with alu_result_in for that operation.
        tag_vld_d[0] = w_handshake;
        tag_idx_d[0] = w_grant_idx;
        for (int k = 1; k < C_STAGES; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_idx_d[k] = tag_idx_q[k-1];
        end

        if (tag_vld_q[C_LAST]) begin
            resp_valid_d  = C_ONE << tag_idx_q[C_LAST];
            resp_result_d = alu_result_in;
        end else begin
            resp_valid_d  = '0;
            resp_result_d = resp_result_q;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_handshake) begin
            rr_ptr_d = (w_grant_idx == C_IDX_W'(NUM_REQ-1)) ? '0
                                                            : w_grant_idx + C_IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tag_vld_q     <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            issue_count_q <= '0;
            for (int k = 0; k < C_STAGES; k++) begin
                tag_idx_q[k] <= '0;
            end
        end else begin
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            tag_vld_q     <= tag_vld_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            issue_count_q <= issue_count_d;
            for (int k = 0; k < C_STAGES; k++) begin
                tag_idx_q[k] <= tag_idx_d[k];
            end
        end
    end

    assign alu_a_out   = alu_a_q;
    assign alu_b_out   = alu_b_q;
    assign alu_op_out  = alu_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign issue_count = issue_count_q;
    assign busy        = (|tag_vld_q) | (|resp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with NUM_REQ=4 and an ALU
//               stub that returns {a,b} one edge after its operands. It
//               compares the DUT against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int OW  = 4;
    localparam int RW  = 16;
    localparam int LAT = 1;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR*OW-1:0]  req_op;
    logic [DW-1:0]     alu_a_out;
    logic [DW-1:0]     alu_b_out;
    logic [OW-1:0]     alu_op_out;
    logic [RW-1:0]     alu_result_in;
    logic [NR-1:0]     resp_valid;
    logic [RW-1:0]     resp_result;
    logic              busy;
    logic [15:0]       issue_count;

    logic [DW-1:0]     fa [NR];
    logic [DW-1:0]     fb [NR];
    logic [OW-1:0]     fo [NR];

    alu_arbiter #(
        .NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .RES_W(RW), .ALU_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
        .alu_result_in(alu_result_in),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .busy(busy), .issue_count(issue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU stub: result {a,b} one edge after operands.
    always_ff @(posedge clock) alu_result_in <= {alu_a_out, alu_b_out};

    always_comb begin
        req_a  = '0;
        req_b  = '0;
        req_op = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = fa[i];
            req_b[i*DW +: DW] = fb[i];
            req_op[i*OW +: OW] = fo[i];
        end
    end

    // Reference model state
    typedef struct {
        int          due;
        int          idx;
        logic [15:0] res;
    } op_t;

    op_t           q[$];
    int            cyc;
    int            m_ptr;
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    logic [15:0]   m_cnt;
    logic [15:0]   m_res;
    logic [NR-1:0] m_rv;
    int            last_g;
    logic [NR-1:0] last_v;
    int            checks;
    int            failures;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [NR-1:0] v);
        int start;
`ifdef ALU_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    // Requesters still waiting on a grant keep their fields stable.
    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            if (!(last_v[i] && last_g != i)) begin
                fa[i] = DW'($urandom);
                fb[i] = DW'($urandom);
                fo[i] = OW'($urandom);
            end
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic step(input logic rst_in, input logic [NR-1:0] v);
        int            g;
        logic [NR-1:0] er;
        reset     = rst_in;
        req_valid = v;
        #2;
        g  = rst_in ? -1 : model_grant(v);
        er = (g >= 0) ? (NR'(1) << g) : '0;
        check_eq("req_ready", {28'd0, req_ready}, {28'd0, er});
        @(posedge clock);
        cyc++;
        if (rst_in) begin
            q.delete();
            m_ptr = 0;
            m_a   = '0;
            m_b   = '0;
            m_op  = '0;
            m_cnt = '0;
            m_res = '0;
            m_rv  = '0;
        end else begin
            if (g >= 0) begin
                m_a   = fa[g];
                m_b   = fb[g];
                m_op  = fo[g];
                m_cnt = m_cnt + 16'd1;
                m_ptr = (g + 1) % NR;
                q.push_back('{due: cyc + LAT + 1, idx: g, res: {fa[g], fb[g]}});
            end
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            if (q.size() > 0 && q[0].due == cyc) begin
                m_rv  = NR'(1) << q[0].idx;
                m_res = q[0].res;
            end else begin
                m_rv = '0;
            end
        end
        last_g = g;
        last_v = v;
        #1;
        check_eq("alu_a", {24'd0, alu_a_out}, {24'd0, m_a});
        check_eq("alu_b", {24'd0, alu_b_out}, {24'd0, m_b});
        check_eq("alu_op", {28'd0, alu_op_out}, {28'd0, m_op});
        check_eq("resp_valid", {28'd0, resp_valid}, {28'd0, m_rv});
        check_eq("resp_result", {16'd0, resp_result}, {16'd0, m_res});
        check_eq("busy", {31'd0, busy}, {31'd0, (q.size() > 0)});
        check_eq("issue_count", {16'd0, issue_count}, {16'd0, m_cnt});
        @(negedge clock);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        m_ptr     = 0;
        m_a       = '0;
        m_b       = '0;
        m_op      = '0;
        m_cnt     = '0;
        m_res     = '0;
        m_rv      = '0;
        last_g    = -1;
        last_v    = '0;
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            fa[i] = '0;
            fb[i] = '0;
            fo[i] = '0;
        end
        @(negedge clock);

        // Reset state
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1111);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_cnt", {16'd0, issue_count}, 32'd0);

        // Single request from requester 2
        fa[2] = 8'h05;
        fb[2] = 8'h03;
        fo[2] = 4'h1;
        step(1'b0, 4'b0100);
        check_eq("t1_alu_a", {24'd0, alu_a_out}, 32'h05);
        check_eq("t1_alu_b", {24'd0, alu_b_out}, 32'h03);
        check_eq("t1_alu_op", {28'd0, alu_op_out}, 32'h1);
        check_eq("t1_cnt", {16'd0, issue_count}, 32'd1);
        step(1'b0, 4'b0000);
        check_eq("t1_no_early_resp", {28'd0, resp_valid}, 32'd0);
        step(1'b0, 4'b0000);
        check_eq("t1_resp_valid", {28'd0, resp_valid}, 32'b0100);
        check_eq("t1_resp_result", {16'd0, resp_result}, 32'h0503);
        step(1'b0, 4'b0000);
        check_eq("t1_resp_once", {28'd0, resp_valid}, 32'd0);

        // Round-robin with all requesters held valid
        step(1'b1, 4'b0000);
        for (int i = 0; i < NR; i++) begin
            fa[i] = 8'(8'h10 + i);
            fb[i] = 8'(8'h20 + i);
            fo[i] = 4'(i);
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 4'b1111);
            check_eq("t2_order", {24'd0, alu_a_out}, {24'd0, 8'(8'h10 + (c % NR))});
        end
        repeat (3) step(1'b0, 4'b0000);

        // Pointer wrap after a grant to requester 3
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1001);
        step(1'b0, 4'b1001);
        repeat (3) step(1'b0, 4'b0000);

        // Reset with operations in flight
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0010);
        step(1'b1, 4'b0000);
        repeat (3) step(1'b0, 4'b0000);
        step(1'b0, 4'b1111);
        check_eq("t4_first_grant", {24'd0, alu_a_out}, {24'd0, fa[0]});
        repeat (3) step(1'b0, 4'b0000);

        // Requesters 1 and 2 held valid (priority behaviour per build)
        for (int c = 0; c < 4; c++) step(1'b0, 4'b0110);
        repeat (3) step(1'b0, 4'b0000);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            logic          r;
            logic [NR-1:0] v;
            r = ($urandom_range(0, 63) == 0);
            v = NR'($urandom_range(0, 15));
            rand_fields();
            step(r, v);
        end

        // Counter wrap
        step(1'b1, 4'b0000);
        for (int c = 0; c < 65537; c++) step(1'b0, 4'b0001);
        check_eq("t6_cnt_wrap", {16'd0, issue_count}, 32'd1);
        repeat (3) step(1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one clocked ALU datapath between N requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one request per cycle (round-robin by default), drives the ALU's a_in/b_in/op_in, tracks in-flight operations with a tag pipeline matched to the ALU latency, and returns each result to its owner. It sits between the requester agents/masters and the ALU instance in the top level.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 8: operand width
- OP_W, 4: opcode width
- RES_W, 16: ALU result width
- ALU_LATENCY, 1: edges from operands applied on alu_a_out/b_out/op_out to valid alu_result_in (1..4)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  grant; at most one bit high; handshake = valid & ready at an edge
- req_a  in  NUM_REQ*DATA_W  operand A; requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing
- req_op  in  NUM_REQ*OP_W  opcode, same packing
- alu_a_out  out  DATA_W  to ALU a_in (registered)
- alu_b_out  out  DATA_W  to ALU b_in (registered)
- alu_op_out  out  OP_W  to ALU op_in (registered)
- alu_result_in  in  RES_W  from ALU result_out
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the owning requester
- resp_result  out  RES_W  result for the pulsed requester
- busy  out  1  any operation in flight
- issue_count  out  16  accepted operations, wrapping

## Operation
- Arbitration is combinational from req_valid and rr_ptr. Search starts at index rr_ptr and ascends modulo NUM_REQ. The first valid requester gets req_ready.
- On a handshake with requester g:
  - rr_ptr <= (g+1) mod NUM_REQ, so NUM_REQ-1 wraps to 0.
  - alu_a_out/b_out/op_out <= requester g's fields.
  - Tag pipeline stage 0 <= {1, g}.
  - issue_count increments, wrapping 0xFFFF -> 0.
- With no handshake:
  - ALU outputs hold their last values.
  - Stage 0 valid <= 0.
  - rr_ptr holds.
- The tag pipeline is ALU_LATENCY+1 stages deep. The last stage aligns with alu_result_in being valid for that operation.
- When the last stage is valid:
  - resp_result <= alu_result_in.
  - resp_valid <= one-hot(tag).
- Otherwise resp_valid <= 0 and resp_result holds.
- Responses have no backpressure. A requester must accept resp_valid when it pulses.
- busy = OR of all tag-stage valids, plus resp_valid.
- A requester may hold req_valid across cycles. Each handshake is one operation.
- Throughput is one operation per cycle. Requests from different requesters may interleave. Responses return in issue order.

## Timing
- Reset values:
  - req_ready = 0 during reset.
  - rr_ptr = 0.
  - All tag valids = 0.
  - resp_valid = 0, resp_result = 0.
  - alu_a_out/b_out/op_out = 0.
  - busy = 0, issue_count = 0.
- Handshake at edge E0 → operands on ALU ports from E0 → resp_valid high for exactly one cycle after edge E0+ALU_LATENCY+1.
- With ALU_LATENCY=1: accept at E0, ALU captures at E1, arbiter captures result at E2, resp visible E2..E3.
- The first cycle after reset deasserts allows a handshake. Requester 0 has top priority then.
- Reset asserted mid-operation:
  - All in-flight operations are dropped. No resp_valid pulses for them, even after reset releases.
  - The rr_ptr and counter reset.
- A requester holding req_valid while another is granted must keep its fields stable. The arbiter samples fields only at the handshake edge.
- A response pulse and a new grant to the same requester in the same cycle are legal and independent.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins. rr_ptr is not implemented and search always starts at 0.
- Not defined: round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
The bench uses an ALU stub that returns {a,b} after ALU_LATENCY=1 edges, with NUM_REQ=4.

1. Single request:
   - Stimulus: requester 2 presents a=0x05, b=0x03, op=0x1.
   - Response: req_ready[2] high the same cycle. alu_a_out=0x05, alu_b_out=0x03, alu_op_out=0x1 after E0. resp_valid=4'b0100 with resp_result=0x0503 after E2, one cycle only. issue_count=1.
2. Round-robin fairness:
   - Stimulus: all 4 req_valid held high for 8 cycles.
   - Response: grant order is 0,1,2,3,0,1,2,3. Responses arrive in the same order, one per cycle. busy stays high until the last resp.
3. Wrap and pointer:
   - Stimulus: after a grant to requester 3, only requesters 0 and 3 valid.
   - Response: requester 0 is granted next, then 3.
4. Reset mid-flight:
   - Stimulus: accept requesters 0 and 1 on consecutive edges, then assert reset for 1 cycle after the second accept.
   - Response: no resp_valid at any point. All outputs return to reset values. The next grant goes to requester 0 when all are valid.
5. Fixed-priority build (ALU_ARB_FIXED_PRIO_EN):
   - Stimulus: requesters 1 and 2 held valid for 4 cycles.
   - Response: requester 1 is granted all 4 cycles and requester 2 never.
6. Counter wrap:
   - Stimulus: 65537 single-requester handshakes.
   - Response: issue_count=1.
